// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_adder_pkg;

  // Control sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal operand width range
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder, reusable by any datapath block.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, a registered carry,
// LSB-first processing, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $fatal(1, "serial_adder: WIDTH must be between 2 and 64");
  end

  state_e             state_q, state_d;
  // Operand A register doubles as the result register: each step shifts
  // out one operand bit at the LSB and shifts one sum bit in at the MSB.
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_y;
  logic               fa_s;
  logic               fa_cout;
  logic               accept;

  full_adder_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (fa_y),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state, datapath shift and result capture logic
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    fa_y    = b_sh_q[0] ^ sub_q;
    accept  = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        a_sh_d  = {fa_s, a_sh_q[WIDTH-1:1]};
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = a_sh_d;
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB during the final step
          ovf_d   = carry_q ^ fa_cout;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction adds ~b plus one; the one enters as the initial carry
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      sub_d   = sub;
      carry_d = sub;
      idx_d   = '0;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (directed cases) and
// WIDTH=2 (all operand/mode combinations).
module tb_serial_adder;

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n8, rst_n2;
  logic       start8, sub8, start2, sub2;
  logic [7:0] a8, b8, sum8;
  logic [1:0] a2, b2, sum2;
  logic       busy8, done8, cout8, ovf8;
  logic       busy2, done2, cout2, ovf2;

  int unsigned cyc = 0;
  int          check_count = 0;
  int          pass_count = 0;
  exp_t        q8[$];
  exp_t        q2[$];
  exp_t        e8, e2;
  logic        done8_prev = 1'b0;
  logic        done2_prev = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issue one operation; the scoreboard entry records the expected done cycle
  task automatic applyStimulus(input int w, input logic s, input logic [7:0] av,
                               input logic [7:0] bv, input logic [7:0] es,
                               input logic ec, input logic eo, input bit push);
    @(negedge clk);
    if (w == 8) begin
      start8 = 1'b1; sub8 = s; a8 = av; b8 = bv;
    end else begin
      start2 = 1'b1; sub2 = s; a2 = av[1:0]; b2 = bv[1:0];
    end
    @(posedge clk);
    #1;
    if (w == 8) begin
      checkOutput("busy8_after_start", 64'(busy8), 64'd1);
      if (push) q8.push_back('{es, ec, eo, cyc + 8});
      start8 = 1'b0;
    end else begin
      checkOutput("busy2_after_start", 64'(busy2), 64'd1);
      if (push) q2.push_back('{es, ec, eo, cyc + 2});
      start2 = 1'b0;
    end
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done8_prev) checkOutput("done8_width", 64'(done8), 64'd0);
    if (done8) begin
      if (q8.size() == 0) begin
        checkOutput("done8_unexpected", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("sum8", 64'(sum8), 64'(e8.sum));
        checkOutput("cout8", 64'(cout8), 64'(e8.cout));
        checkOutput("ovf8", 64'(ovf8), 64'(e8.ovf));
        checkOutput("done8_cycle", 64'(cyc), 64'(e8.cyc));
        checkOutput("busy8_at_done", 64'(busy8), 64'd0);
      end
    end
    done8_prev = done8;
  end

  // Monitor for the 2-bit instance
  always @(negedge clk) begin
    if (done2_prev) checkOutput("done2_width", 64'(done2), 64'd0);
    if (done2) begin
      if (q2.size() == 0) begin
        checkOutput("done2_unexpected", 64'd1, 64'd0);
      end else begin
        e2 = q2.pop_front();
        checkOutput("sum2", 64'(sum2), 64'(e2.sum));
        checkOutput("cout2", 64'(cout2), 64'(e2.cout));
        checkOutput("ovf2", 64'(ovf2), 64'(e2.ovf));
        checkOutput("done2_cycle", 64'(cyc), 64'(e2.cyc));
      end
    end
    done2_prev = done2;
  end

  initial begin
    int unsigned t0c;
    logic [1:0]  y;
    logic [2:0]  tot;
    logic [1:0]  es2;

    rst_n8 = 1'b0; rst_n2 = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy8", 64'(busy8), 64'd0);
    checkOutput("rst_done8", 64'(done8), 64'd0);
    checkOutput("rst_sum8", 64'(sum8), 64'd0);
    checkOutput("rst_cout8", 64'(cout8), 64'd0);
    checkOutput("rst_ovf8", 64'(ovf8), 64'd0);
    checkOutput("rst_busy2", 64'(busy2), 64'd0);
    checkOutput("rst_done2", 64'(done2), 64'd0);
    checkOutput("rst_sum2", 64'(sum2), 64'd0);
    rst_n8 = 1'b1; rst_n2 = 1'b1;

    $display("[TB] 8-bit directed operations");
    applyStimulus(8, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    repeat (9) @(posedge clk);
    applyStimulus(8, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    applyStimulus(8, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1);
    repeat (9) @(posedge clk);

    // Start pulse during busy must be ignored and must not disturb operands
    applyStimulus(8, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("held_sum8", 64'(sum8), 64'h00);
    checkOutput("held_busy8", 64'(busy8), 64'd0);

    $display("[TB] back-to-back operations");
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
    @(posedge clk);
    #1;
    t0c = cyc;
    q8.push_back('{8'h03, 1'b0, 1'b0, t0c + 8});
    q8.push_back('{8'h30, 1'b0, 1'b0, t0c + 17});
    a8 = 8'h10; b8 = 8'h20;
    repeat (9) @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] reset during an operation");
    applyStimulus(8, 1'b0, 8'hAA, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n8 = 1'b0;
    #1;
    checkOutput("abort_busy8", 64'(busy8), 64'd0);
    checkOutput("abort_done8", 64'(done8), 64'd0);
    checkOutput("abort_sum8", 64'(sum8), 64'd0);
    checkOutput("abort_cout8", 64'(cout8), 64'd0);
    checkOutput("abort_ovf8", 64'(ovf8), 64'd0);
    repeat (12) @(negedge clk);
    rst_n8 = 1'b1;
    applyStimulus(8, 1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);

    $display("[TB] 2-bit exhaustive sweep");
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 4; av++) begin
        for (int bv = 0; bv < 4; bv++) begin
          y   = (s == 1) ? ~2'(bv) : 2'(bv);
          tot = 3'(av) + 3'(y) + 3'(s);
          es2 = tot[1:0];
          applyStimulus(2, 1'(s), 8'(av), 8'(bv), {6'd0, es2}, tot[2],
                        (2'(av) >> 1 == y >> 1) && (es2[1] != 1'(av >> 1)), 1'b1);
          repeat (2) @(posedge clk);
        end
      end
    end
    repeat (5) @(negedge clk);

    checkOutput("q8_drained", 64'(q8.size()), 64'd0);
    checkOutput("q2_drained", 64'(q2.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
